// File: rtl/rsa_encrypt_seq.sv
// Sequential modular exponentiation C = M^e mod n, right-to-left square-and-multiply.
// Fixed latency: done pulses W+1 edges after the accepting start; start is ignored while busy.
module rsa_encrypt_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] M,
    input  logic [W-1:0] e,
    input  logic [W-1:0] n,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] C,
    output logic         err
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    exp_q,   exp_d;
    logic [W-1:0]    mod_q,   mod_d;
    logic [W-1:0]    base_q,  base_d;
    logic [W-1:0]    acc_q,   acc_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [W-1:0]    c_q,     c_d;
    logic            err_q,   err_d;
    logic            nz_q,    nz_d;

    // A zero modulus is steered to a divisor of 1 so the reducers never divide by
    // zero; every residue then collapses to 0, which is the required C for n=0.
    logic [W-1:0]    in_div;
    logic [2*W-1:0]  run_div;
    logic [2*W-1:0]  acc_prod;
    logic [2*W-1:0]  base_prod;
    logic [W-1:0]    acc_red;
    logic [W-1:0]    base_red;
    logic [W-1:0]    acc_step;

    assign in_div    = (n == '0) ? W'(1) : n;
    assign run_div   = (mod_q == '0) ? (2*W)'(1) : {{W{1'b0}}, mod_q};
    assign acc_prod  = {{W{1'b0}}, acc_q}  * {{W{1'b0}}, base_q};
    assign base_prod = {{W{1'b0}}, base_q} * {{W{1'b0}}, base_q};
    assign acc_red   = W'(acc_prod % run_div);
    assign base_red  = W'(base_prod % run_div);
    assign acc_step  = exp_q[0] ? acc_red : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            exp_q   <= '0;
            mod_q   <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            nz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            mod_q   <= mod_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            err_q   <= err_d;
            nz_q    <= nz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        mod_d   = mod_q;
        base_d  = base_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        err_d   = err_q;
        nz_d    = nz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d   = e;
                    mod_d   = n;
                    base_d  = M % in_div;
                    acc_d   = (n > W'(1)) ? W'(1) : '0;
                    cnt_d   = '0;
                    nz_d    = (n == '0);
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_step;
                base_d = base_red;
                exp_d  = exp_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    c_d     = acc_step;
                    err_d   = nz_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign C    = c_q;
    assign err  = err_q;

endmodule

// File: tb/tb_rsa_encrypt_seq.sv
// Directed-vector and corner-sequence bench for rsa_encrypt_seq at W=8.
module tb_rsa_encrypt_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] M, e, n;
    logic         busy, done, err;
    logic [W-1:0] C;

    int n_tests = 0;
    int n_fail  = 0;

    rsa_encrypt_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .M     (M),
        .e     (e),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .C     (C),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] ex;
        logic [W-1:0] md;
        logic [W-1:0] exp_c;
        logic         exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Repeated multiplication, deliberately unlike the square-and-multiply datapath.
    function automatic int ref_pow(input int b, input int x, input int md);
        longint r;
        if (md == 0) return 0;
        r = 1 % md;
        for (int i = 0; i < x; i++) r = (r * (b % md)) % md;
        return int'(r);
    endfunction

    // Wait up to a bound for done; returns the number of edges it took.
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < W + 6) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_vec(input string nm, input logic [W-1:0] m, input logic [W-1:0] ex,
                           input logic [W-1:0] md, input int exp_c, input int exp_err);
        int edges;
        @(negedge clk);
        M = m; e = ex; n = md; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        M = W'($urandom); e = W'($urandom); n = W'($urandom);
        chk({nm, "_busy_run"}, int'(busy), 1);
        wait_done(edges);
        chk({nm, "_latency"}, edges, W);
        chk({nm, "_C"}, int'(C), exp_c);
        chk({nm, "_err"}, int'(err), exp_err);
        @(posedge clk); #1;
        chk({nm, "_done_width"}, int'(done), 0);
        chk({nm, "_busy_idle"}, int'(busy), 0);
        chk({nm, "_C_hold"}, int'(C), exp_c);
    endtask

    initial begin
        int edges, pulses;
        logic [W-1:0] rm, re, rn;

        vecs[0]  = '{8'd2,   8'd7,   8'd33,  8'd29,  1'b0};
        vecs[1]  = '{8'd5,   8'd7,   8'd33,  8'd14,  1'b0};
        vecs[2]  = '{8'd40,  8'd1,   8'd33,  8'd7,   1'b0};
        vecs[3]  = '{8'd9,   8'd0,   8'd33,  8'd1,   1'b0};
        vecs[4]  = '{8'd9,   8'd5,   8'd1,   8'd0,   1'b0};
        vecs[5]  = '{8'd9,   8'd5,   8'd0,   8'd0,   1'b1};
        vecs[6]  = '{8'd0,   8'd5,   8'd33,  8'd0,   1'b0};
        vecs[7]  = '{8'd3,   8'd4,   8'd7,   8'd4,   1'b0};
        vecs[8]  = '{8'd255, 8'd255, 8'd251, 8'd20,  1'b0};
        vecs[9]  = '{8'd200, 8'd2,   8'd255, 8'd220, 1'b0};
        vecs[10] = '{8'd7,   8'd255, 8'd2,   8'd1,   1'b0};

        rst_n = 1'b0; start = 1'b0; M = '0; e = '0; n = '0;
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_C",    int'(C),    0);
        chk("reset_err",  int'(err),  0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_vec($sformatf("vec%0d", i), vecs[i].m, vecs[i].ex, vecs[i].md,
                    int'(vecs[i].exp_c), int'(vecs[i].exp_err));

        // Second start three cycles into RUN must be dropped.
        @(negedge clk);
        M = 8'd2; e = 8'd7; n = 8'd33; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        M = 8'd5; e = 8'd3; n = 8'd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3 * W; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++;
                chk("ignore_start_C", int'(C), 29);
            end
        end
        chk("ignore_start_pulses", pulses, 1);

        // Async reset mid-RUN: outputs clear without a clock edge, no done pulse.
        @(negedge clk);
        M = 8'd5; e = 8'd7; n = 8'd33; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_C",    int'(C),    0);
        chk("arst_err",  int'(err),  0);
        pulses = 0;
        for (int c = 0; c < 2 * W; c++) begin
            @(posedge clk); #1;
            if (c == 3) rst_n = 1'b1;
            if (done === 1'b1) pulses++;
        end
        chk("arst_no_done", pulses, 0);
        run_vec("post_reset", 8'd5, 8'd7, 8'd33, 14, 0);

        // start held high relaunches on the first IDLE edge after DONE.
        @(negedge clk);
        M = 8'd2; e = 8'd7; n = 8'd33; start = 1'b1;
        @(posedge clk); #1;
        wait_done(edges);
        chk("held_first_lat", edges, W);
        chk("held_first_C", int'(C), 29);
        M = 8'd40; e = 8'd1;
        @(posedge clk); #1;
        chk("held_idle_gap", int'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("held_relaunch", int'(busy), 1);
        wait_done(edges);
        chk("held_second_lat", edges, W);
        chk("held_second_C", int'(C), 7);
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            rm = W'($urandom);
            re = W'($urandom);
            rn = W'($urandom_range(255, 2));
            run_vec($sformatf("rnd%0d", i), rm, re, rn, ref_pow(int'(rm), int'(re), int'(rn)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_encrypt_seq.md
RSA_ENCRYPT_SEQ -- requirements
Module: rsa_encrypt_seq

Interface
REQ-001 The block SHALL have one parameter: W, default 8, operand/result width in bits.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port start, input, 1: request pulse; sampled only in IDLE.
REQ-005 Port M, input, W: plaintext.
REQ-006 Port e, input, W: public exponent.
REQ-007 Port n, input, W: modulus.
REQ-008 Port busy, output, 1: high while a computation is in progress (RUN or DONE).
REQ-009 Port done, output, 1: one-cycle pulse marking C and err valid.
REQ-010 Port C, output, W: ciphertext, C = M^e mod n.
REQ-011 Port err, output, 1: high when the captured n was 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at edge k, the block SHALL capture the operands.
- exp = e, mod = n, base = M mod n, acc = 1 mod n, bit counter = 0
- State goes to RUN.
REQ-014 Inputs M, e and n SHALL be ignored outside edge k; changing them mid-operation SHALL NOT affect the result.
REQ-015 RUN SHALL process one exponent bit per cycle, LSB first, using right-to-left square-and-multiply.
- If exp[0]=1: acc = (acc*base) mod mod
- Always: base = (base*base) mod mod
- exp shifts right by 1; counter increments
REQ-016 Products SHALL be formed at 2W bits before reduction, so no intermediate value overflows.
REQ-017 RUN SHALL last exactly W cycles regardless of the value of e, giving constant latency.
REQ-018 On the edge that completes the W-th RUN step (edge k+W), the block SHALL register C = final acc and set state to DONE.
REQ-019 In DONE, done=1 for exactly one cycle (the cycle after edge k+W); the next edge SHALL return the FSM to IDLE.
REQ-020 C and err SHALL hold their values after DONE until the next accepted start.
REQ-021 busy SHALL be 1 from the cycle after edge k through the DONE cycle inclusive, and 0 in IDLE.
REQ-022 A start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-023 A start held high continuously SHALL launch a new computation at the first IDLE edge after DONE.
REQ-024 Boundary: n=0 SHALL give C=0 and err=1, with the same latency and the same done pulse; no divide by zero shall occur in the datapath.
REQ-025 Boundary: n=1 SHALL give C=0 and err=0.
REQ-026 Boundary: e=0 with n>1 SHALL give C=1.
REQ-027 Boundary: M>=n SHALL be reduced mod n at capture; M=0 with e>0 SHALL give C=0.
REQ-028 err SHALL be registered together with C and is valid under the same rules.

Reset
REQ-029 rst_n=0 SHALL immediately force, independent of clk:
- state=IDLE
- busy=0, done=0, C=0, err=0
- all internal registers to 0
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-031 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-032 M=2, e=7, n=33, start pulse at edge k -> done=1 in the cycle after edge k+8, C=29, err=0; C=29 matches the decrypt-stage vector (C=29, d=3, n=33, giving P=2).
REQ-033 M=5, e=7, n=33 -> C=14 (decrypting 14 with d=3 returns 5); M=40, e=1, n=33 -> C=7.
REQ-034 e=0, n=33, M=9 -> C=1; n=1 -> C=0; n=0 -> C=0 with err=1; all three at latency W+1 edges.
REQ-035 start pulsed again 3 cycles into RUN with different operands -> ignored; first result returned unchanged; exactly one done pulse.
REQ-036 rst_n pulsed low mid-RUN -> outputs 0 asynchronously, no done pulse; a new start after release completes with the correct C.
REQ-037 Random sweep at W=8: M, e and n drawn with n>=2 -> C equals the reference model pow(M,e) mod n, done is always one cycle wide, and busy/done timing is as in REQ-018 to REQ-021.
